// File: rtl/stream_min_tracker.sv
// stream_min_tracker: sequential frame-minimum reducer.
// Accepts one unsigned sample per cycle, tracks the running minimum and the
// index of its first occurrence, and presents {min, idx, count, ovf} once the
// frame closes (in_last, or force-closed after 2^IDX_W samples).
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid never waits on ready, and an offered beat (data/last) must be
// held stable until it transfers.
module stream_min_tracker #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_min,
  output logic [IDX_W-1:0]   out_idx,
  output logic [IDX_W:0]     out_count,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         state
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            fsm;
  logic [WIDTH-1:0]  run_min;
  logic [IDX_W-1:0]  run_idx;
  logic [CNT_W-1:0]  count;

  logic [WIDTH-1:0]  next_min;
  logic [IDX_W-1:0]  next_idx;
  logic [CNT_W-1:0]  next_count;
  logic              take;
  logic              close;

  assign state = fsm;

  // Running values after accepting the current sample; ties keep the older index.
  always_comb begin
    take       = in_valid && in_ready;
    next_min   = run_min;
    next_idx   = run_idx;
    next_count = count;
    if (fsm == IDLE) begin
      next_min   = in_data;
      next_idx   = '0;
      next_count = CNT_W'(1);
    end else begin
      next_count = count + CNT_W'(1);
      if (in_data < run_min) begin
        next_min = in_data;
        next_idx = count[IDX_W-1:0];
      end
    end
    close = in_last || (next_count == MAX_COUNT);
  end

  // Frame FSM with registered handshake flags and result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      out_min   <= '1;
      out_idx   <= '0;
      out_count <= '0;
      run_min   <= '1;
      run_idx   <= '0;
      count     <= '0;
    end else begin
      case (fsm)
        IDLE, ACCUM: begin
          if (take) begin
            run_min <= next_min;
            run_idx <= next_idx;
            count   <= next_count;
            if (close) begin
              fsm       <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_min   <= next_min;
              out_idx   <= next_idx;
              out_count <= next_count;
              out_ovf   <= !in_last;
            end else begin
              fsm <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            run_min   <= '1;
            run_idx   <= '0;
            count     <= '0;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_tracker.sv
// Bench for stream_min_tracker: directed test-plan frames plus randomized
// frames, scored against a frame-level reference model.
module tb_stream_min_tracker;

  localparam int W     = 16;
  localparam int IW    = 8;
  localparam int MAXN  = 1 << IW;
  localparam int RES_W = W + IW + (IW + 1) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (IDX_W = 8)
  logic [W-1:0]  in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_last  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_min;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_count;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    dbg_state;

  // small DUT (IDX_W = 2) for the force-close case
  logic [W-1:0]  s_in_data  = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_last  = 1'b0;
  logic          s_in_ready;
  logic [W-1:0]  s_out_min;
  logic [1:0]    s_out_idx;
  logic [2:0]    s_out_count;
  logic          s_out_ovf;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic [1:0]    s_dbg_state;

  stream_min_tracker #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_min(out_min), .out_idx(out_idx), .out_count(out_count), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .state(dbg_state)
  );

  stream_min_tracker #(.WIDTH(W), .IDX_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_last(s_in_last), .in_ready(s_in_ready),
    .out_min(s_out_min), .out_idx(s_out_idx), .out_count(s_out_count), .out_ovf(s_out_ovf),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .state(s_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]     frame[$];
  logic [RES_W-1:0] exp_q[$];
  bit               rdy_random = 1'b0;

  function automatic logic [RES_W-1:0] reduce(input logic [W-1:0] q[$], input logic ovf);
    logic [W-1:0]  m;
    logic [IW-1:0] ix;
    logic [IW:0]   cnt;
    m  = q[0];
    ix = '0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] < m) begin
        m  = q[i];
        ix = IW'(i);
      end
    end
    cnt = (IW + 1)'(q.size());
    return {m, ix, cnt, ovf};
  endfunction

  // Observe at the falling edge: the values seen here are what the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      frame.delete();
      exp_q.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      if (out_valid && exp_q.size() != 0) begin
        check("result", 64'({out_min, out_idx, out_count, out_ovf}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        frame.push_back(in_data);
        if (in_last || frame.size() == MAXN) begin
          exp_q.push_back(reduce(frame, !in_last));
          frame.delete();
        end
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_random) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_min", 64'(out_min), 64'hFFFF);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    frame.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int  n   = 0;
    bit  acc = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = W'($urandom);
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] m,
                               input logic [IW-1:0] ix, input logic [IW:0] c, input logic o);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_min"}, 64'(out_min), 64'(m));
    check({tag, "_idx"}, 64'(out_idx), 64'(ix));
    check({tag, "_count"}, 64'(out_count), 64'(c));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(o));
    @(posedge clk);
    #1;
  endtask

  task automatic s_send(input logic [W-1:0] d, input logic l);
    int n   = 0;
    bit acc = 1'b0;
    s_in_data  = d;
    s_in_last  = l;
    s_in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_in_valid = 1'b0;
    check("s_send_accept", 64'(acc), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();

    // Plain frame, consumer always ready.
    out_ready = 1'b1;
    send(16'd10, 1'b0);
    send(16'd20, 1'b0);
    send(16'd5, 1'b0);
    send(16'd30, 1'b1);
    check("lat_valid", 64'(out_valid), 64'd1);
    expect_result("basic", 16'd5, 8'd2, 9'd4, 1'b0);

    // Ties keep the earliest index.
    send(16'd40, 1'b0);
    send(16'd7, 1'b0);
    send(16'd7, 1'b0);
    send(16'd9, 1'b1);
    expect_result("ties", 16'd7, 8'd1, 9'd4, 1'b0);

    // Single all-ones sample.
    send(16'hFFFF, 1'b1);
    expect_result("single", 16'hFFFF, 8'd0, 9'd1, 1'b0);

    // Backpressure: result held while the next frame waits.
    out_ready = 1'b0;
    send(16'd50, 1'b0);
    send(16'd60, 1'b1);
    fork
      send(16'd70, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_min", 64'(out_min), 64'd50);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    expect_result("bp_next", 16'd70, 8'd0, 9'd1, 1'b0);

    // Asynchronous reset mid-frame.
    send(16'd20, 1'b0);
    send(16'd4, 1'b0);
    do_reset();
    send(16'd12, 1'b0);
    send(16'd6, 1'b1);
    expect_result("post_rst", 16'd6, 8'd1, 9'd2, 1'b0);

    // Force-close on the IDX_W = 2 instance.
    s_out_ready = 1'b0;
    s_send(16'd9, 1'b0);
    s_send(16'd3, 1'b0);
    s_send(16'd8, 1'b0);
    s_send(16'd3, 1'b0);
    check("ovf_valid", 64'(s_out_valid), 64'd1);
    check("ovf_min", 64'(s_out_min), 64'd3);
    check("ovf_idx", 64'(s_out_idx), 64'd1);
    check("ovf_count", 64'(s_out_count), 64'd4);
    check("ovf_flag", 64'(s_out_ovf), 64'd1);
    s_out_ready = 1'b1;
    s_send(16'd1, 1'b0);
    s_send(16'd2, 1'b1);
    check("ovf_next_valid", 64'(s_out_valid), 64'd1);
    check("ovf_next_min", 64'(s_out_min), 64'd1);
    check("ovf_next_idx", 64'(s_out_idx), 64'd0);
    check("ovf_next_count", 64'(s_out_count), 64'd2);
    check("ovf_next_flag", 64'(s_out_ovf), 64'd0);

    // Randomized frames with bubbles and random consumer stalls.
    rdy_random = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        logic [W-1:0] v;
        v = (f % 2 == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
        if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
        send(v, (i == len - 1));
      end
    end

    // Long frame: force-closed at 256, remainder closed by in_last.
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom_range(100, 60000)), (i == 299));
    end

    // Drain.
    rdy_random = 1'b0;
    out_ready  = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_min_tracker.md
Name: stream_min_tracker

Overview:
- Streaming reduction unit: accepts a frame of unsigned WIDTH-bit samples over a valid/ready input handshake and reports the frame minimum, its index and the sample count over a valid/ready output handshake.
- It is the reverse-direction counterpart to the team's combinational two-operand max selector. It works sequentially, one sample per cycle, and selects the minimum instead of the maximum.
- Sits between a sample producer and a result consumer in the datapath test harness.

Parameters:
- WIDTH, 16, sample and result width (unsigned).
- IDX_W, 8, index width; maximum frame length is 2^IDX_W samples.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  sample value.
- in_valid  input  1  producer offers in_data/in_last.
- in_last  input  1  current sample is the final sample of the frame.
- in_ready  output  1  block can accept a sample this cycle.
- out_min  output  WIDTH  minimum value of the completed frame.
- out_idx  output  IDX_W  zero-based index of the first occurrence of the minimum.
- out_count  output  IDX_W+1  number of samples in the frame (1..2^IDX_W).
- out_ovf  output  1  frame was force-closed at 2^IDX_W samples without in_last.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, out_ovf = 0.
  - out_min = all ones, out_idx = 0, out_count = 0.
  - Internal running min = all ones, running idx = 0, count = 0.
- Input transfer: a sample transfers when in_valid && in_ready at a rising edge. Nothing else changes state on the input side.
- Output transfer: a result transfers when out_valid && out_ready at a rising edge.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On the first transfer:
    - running min = in_data, idx = 0, count = 1.
    - If in_last, or IDX_W = 0, go to DONE; else go to ACCUM.
  - ACCUM: in_ready = 1, out_valid = 0. On each transfer:
    - If in_data < running min (strict unsigned compare), running min = in_data and idx = count.
    - count increments.
    - If in_last, go to DONE with out_ovf = 0.
    - Else if the new count == 2^IDX_W, go to DONE with out_ovf = 1.
  - DONE: in_ready = 0, out_valid = 1. Outputs are registered copies of min, idx, count and ovf, and hold stable until out_ready.
    - On output transfer: go to IDLE, clear running state, out_valid = 0 on the next cycle.
- Latency: out_valid rises on the cycle after the edge that accepted the last sample. Throughput is one sample per cycle within a frame. There is one idle cycle in DONE per frame at minimum, so there is no overlap between frames.
- Ties: an equal value never replaces the minimum, so out_idx always reports the earliest occurrence.
- Compare is unsigned and full WIDTH. count is IDX_W+1 bits so that 2^IDX_W is representable.
- Input side while in_valid = 0: no state change in any state. in_data and in_last are ignored when in_valid = 0.
- in_valid in DONE: ignored (in_ready = 0). The producer must hold the sample; it is not dropped.
- out_ready held high in DONE: the result transfers on the first DONE edge.
- Single-sample frame (in_last on the first sample): out_min = that sample, out_idx = 0, out_count = 1.
- Asynchronous reset mid-frame or in DONE: the partial frame or pending result is discarded immediately and all outputs take their reset values without waiting for a clock edge.
- Bubbles inside a frame are legal: in_valid low for any number of cycles in ACCUM keeps all state.

Test Plan:
- Frame 10, 20, 5, 30 (last on 30), out_ready = 1:
  - out_valid exactly one cycle after the 30 transfer.
  - out_min = 5, out_idx = 2, out_count = 4, out_ovf = 0.
- Frame 40, 7, 7, 9 (last) with ties:
  - out_min = 7, out_idx = 1, out_count = 4.
- Single sample 16'hFFFF with in_last:
  - out_min = 65535, out_idx = 0, out_count = 1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid while in_valid = 1:
  - Results remain stable and in_ready stays 0.
  - The next frame's first sample is accepted only on the cycle after the out_ready = 1 transfer.
- Overflow with IDX_W = 2: feed 5 samples with no in_last (values 9, 3, 8, 3, 1):
  - Result after the 4th sample: min = 3, idx = 1, count = 4, out_ovf = 1.
  - Sample 1 then starts a new frame.
- Assert rst asynchronously mid-frame after 20, 4:
  - Outputs immediately at reset values.
  - A subsequent frame 12, 6 (last) yields min = 6, idx = 1, count = 2, with no contamination from the value 4.
